// File: rtl/sha3_pkg.sv
// sha3_pkg: shared SHA3 sponge controller state encoding and SHA3-256 sizing constants
package sha3_pkg;
  localparam int SHA3_RATE_WORDS = 68;
  localparam int SHA3_OUT_WORDS = 16;
  typedef enum logic [2:0] {IDLE, ABSORB, FILL, PERM_START, PERM_WAIT, SQUEEZE, DONE} state_t;
endpackage

// File: rtl/sha3_sponge_ctrl_if.sv
// sha3_sponge_ctrl_if: AXI-Stream message input and digest output of the sponge controller
interface sha3_sponge_ctrl_if #(parameter int DATA_WIDTH = 16);
  logic s_tvalid, s_tready, s_tlast;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic m_tvalid, m_tready, m_tlast;
  logic [DATA_WIDTH-1:0] m_tdata;
  modport slave (input s_tvalid, s_tlast, s_tdata, m_tready, output s_tready, m_tvalid, m_tlast, m_tdata);
  modport master (output s_tvalid, s_tlast, s_tdata, m_tready, input s_tready, m_tvalid, m_tlast, m_tdata);
endinterface

// File: rtl/sha3_sponge_ctrl.sv
// sha3_sponge_ctrl: sequences absorb, zero-fill, permutation and squeeze over an external Keccak state
module sha3_sponge_ctrl import sha3_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int RATE_WORDS = SHA3_RATE_WORDS,
  parameter int OUT_WORDS = SHA3_OUT_WORDS,
  localparam int WW = $clog2(RATE_WORDS),
  localparam int RW = $clog2(OUT_WORDS)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  sha3_sponge_ctrl_if.slave     axis,
  output logic                  st_wr_en,
  output logic [WW-1:0]         st_wr_idx,
  output logic [DATA_WIDTH-1:0] st_wr_data,
  output logic                  st_clr,
  output logic                  perm_start,
  input  logic                  perm_done,
  output logic [RW-1:0]         st_rd_idx,
  input  logic [DATA_WIDTH-1:0] st_rd_data,
  output logic                  busy
);
  state_t state;
  logic [WW-1:0] word_cnt;
  logic [RW-1:0] out_cnt;
  logic last_blk, beat, m_beat, wr_last, o_last;
  always_comb begin
    beat = axis.s_tready && axis.s_tvalid;
    wr_last = word_cnt == WW'(RATE_WORDS - 1);
    o_last = out_cnt == RW'(OUT_WORDS - 1);
    axis.s_tready = state inside {IDLE, ABSORB};
    axis.m_tvalid = state == SQUEEZE;
    axis.m_tlast = axis.m_tvalid && o_last;
    axis.m_tdata = st_rd_data;
    m_beat = axis.m_tvalid && axis.m_tready;
    st_wr_en = beat || state == FILL;
    st_wr_idx = word_cnt;
    st_wr_data = beat ? axis.s_tdata : '0;
    st_clr = (state == IDLE && beat) || state == DONE;
    st_rd_idx = out_cnt;
    busy = state != IDLE;
  end
  // perm_start is registered off PERM_START, landing two cycles after the block's final beat
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      word_cnt <= '0;
      out_cnt <= '0;
      last_blk <= 1'b0;
      perm_start <= 1'b0;
    end else begin
      perm_start <= state == PERM_START;
      case (state)
        IDLE, ABSORB: if (beat) begin
          word_cnt <= wr_last ? '0 : word_cnt + 1'b1;
          last_blk <= last_blk || axis.s_tlast;
          state <= wr_last ? PERM_START : axis.s_tlast ? FILL : ABSORB;
        end
        FILL: begin
          word_cnt <= wr_last ? '0 : word_cnt + 1'b1;
          state <= wr_last ? PERM_START : FILL;
        end
        PERM_START: state <= PERM_WAIT;
        PERM_WAIT: if (perm_done) state <= last_blk ? SQUEEZE : ABSORB;
        SQUEEZE: if (m_beat) begin
          out_cnt <= o_last ? '0 : out_cnt + 1'b1;
          state <= o_last ? DONE : SQUEEZE;
        end
        DONE: begin
          state <= IDLE;
          word_cnt <= '0;
          out_cnt <= '0;
          last_blk <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sha3_sponge_ctrl.md
SHA3_SPONGE_CTRL -- requirements
Module: sha3_sponge_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of stream words and state-access words.
REQ-002 SHALL have parameter RATE_WORDS, default 68, number of DATA_WIDTH words per absorb block (SHA3-256: 1088 bits).
REQ-003 SHALL have parameter OUT_WORDS, default 16, number of DATA_WIDTH digest words squeezed.
REQ-004 SHALL have port ACLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ARESET, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have ports s_tvalid/s_tready/s_tlast, in/out/in, 1 bit each: AXI-Stream slave handshake for padded message words.
REQ-007 SHALL have port s_tdata, input, DATA_WIDTH, message word.
REQ-008 SHALL have ports st_wr_en (out, 1), st_wr_idx (out, $clog2(RATE_WORDS)), st_wr_data (out, DATA_WIDTH): XOR-write of one rate word into the state register.
REQ-009 SHALL have port st_clr, output, 1 bit, one-cycle pulse that zeroes the state register.
REQ-010 SHALL have ports perm_start (out, 1) and perm_done (in, 1): Keccak-f start pulse and completion pulse.
REQ-011 SHALL have ports st_rd_idx (out, $clog2(OUT_WORDS)) and st_rd_data (in, DATA_WIDTH): combinational digest-word read.
REQ-012 SHALL have ports m_tvalid/m_tready/m_tlast (out/in/out, 1) and m_tdata (out, DATA_WIDTH): AXI-Stream master for the digest.
REQ-013 SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ABSORB, FILL, PERM_START, PERM_WAIT, SQUEEZE, DONE.
REQ-015 IDLE: s_tready=1; on an s_tvalid beat, write the word at index 0, pulse st_clr in the same cycle (clear takes priority over the write in the state register), set word_cnt=1, go ABSORB (or handle tlast/full per REQ-017/018).
REQ-016 ABSORB: s_tready=1; each accepted beat drives st_wr_en=1, st_wr_idx=word_cnt, st_wr_data=s_tdata in the same cycle, then word_cnt increments.
REQ-017 Beat at word_cnt==RATE_WORDS-1: word_cnt wraps to 0, last_blk latches s_tlast, next state PERM_START.
REQ-018 Beat with s_tlast=1 and word_cnt<RATE_WORDS-1: last_blk=1, next state FILL.
REQ-019 FILL: s_tready=0; one zero-word write per cycle at the remaining indices up to RATE_WORDS-1, then PERM_START.
REQ-020 PERM_START: perm_start=1 for exactly one cycle, s_tready=0, next state PERM_WAIT.
REQ-021 PERM_WAIT: s_tready=0; on perm_done go SQUEEZE if last_blk, else ABSORB. perm_done in any other state SHALL be ignored.
REQ-022 SQUEEZE: m_tvalid=1, m_tdata=st_rd_data, st_rd_idx=out_cnt; advance out_cnt only on m_tvalid&&m_tready; m_tlast=1 when out_cnt==OUT_WORDS-1; after that beat go DONE.
REQ-023 m_tdata/m_tlast SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-024 DONE: st_clr pulse for one cycle, clear last_blk and counters, go IDLE.
REQ-025 A complete block of RATE_WORDS beats SHALL issue perm_start exactly two cycles after the accepting edge of the last beat.
REQ-026 Permutation latency SHALL be unconstrained; the FSM waits in PERM_WAIT indefinitely.

Reset
REQ-027 While ARESET=1 at a clock edge: state=IDLE, word_cnt=0, out_cnt=0, last_blk=0.
REQ-028 Outputs during and after reset: s_tready=1 (IDLE), st_wr_en, st_clr, perm_start, m_tvalid, m_tlast, busy=0; st_wr_idx, st_rd_idx, st_wr_data=0.
REQ-029 Reset asserted in any state SHALL abort the operation without a perm_start or m_tvalid pulse in the following cycle.

Structure
REQ-030 The FSM state enum and the SHA3-256 constants (RATE_WORDS=68, OUT_WORDS=16) SHALL live in the shared package sha3_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the state register and permutation remain external.

Verification
REQ-032 RATE_WORDS=4, OUT_WORDS=2: 4 beats 0x0001..0x0004, tlast on 4th -> wr_idx 0..3, perm_start 2 cycles later; perm_done -> 2 digest beats, m_tlast on 2nd, st_clr, IDLE.
REQ-033 RATE_WORDS=4: 2 beats with tlast on 2nd -> FILL writes 0x0000 at idx 2,3 with s_tready=0, then one perm_start.
REQ-034 RATE_WORDS=4: 8 beats, tlast on 8th -> two perm_starts; s_tready=0 between blocks until first perm_done.
REQ-035 SQUEEZE with m_tready toggled 1,0,0,1 -> m_tdata held during stall, exactly OUT_WORDS beats total.
REQ-036 ARESET pulsed in PERM_WAIT, then perm_done -> no SQUEEZE, busy=0, s_tready=1.
REQ-037 perm_done pulsed in IDLE/ABSORB -> ignored, no state change.
